// File: rtl/demux32_deser.sv
// -----------------------------------------------------------------------------
// demux32_deser
//
// Serial-to-parallel word builder. This is the inverse of a 32:1 bit-select mux
// tree. Each accepted serial bit is steered into one position of a shadow word.
// That position is chosen by the idx bit counter. Once WIDTH bits have been
// collected, the word moves to an output register and is offered on a
// valid/ready handshake.
//
// If the output register is still occupied when a word completes, the finished
// word is parked in the shadow register (state HOLD). Input is then stalled
// until the consumer takes the older word.
//
// Parameters:
//   WIDTH     word width in bits; must equal 2**SEL_W
//   SEL_W     width of the bit-position counter
//   MSB_FIRST 0: first bit lands in word[0]; 1: first bit lands in word[WIDTH-1]
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear of partial word / idx (wins over in_valid)
//   in_bit    serial data bit
//   in_valid  in_bit qualifier
//   in_ready  a bit can be accepted this cycle (registered, state-only)
//   out_word  assembled word
//   out_valid out_word holds an unconsumed word
//   out_ready consumer accepts out_word
//   sel       current bit index (bits already collected in this word)
//   overrun   sticky flag: in_valid seen while in_ready was low
// -----------------------------------------------------------------------------
module demux32_deser #(
  parameter int WIDTH     = 32,
  parameter int SEL_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             overrun
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shadow_q,    shadow_d;
  logic [WIDTH-1:0] out_word_q,  out_word_d;
  logic [SEL_W-1:0] idx_q,       idx_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q,   overrun_d;
  logic             in_ready_q,  in_ready_d;

  logic [SEL_W-1:0] pos;
  logic [WIDTH-1:0] shadow_wr;
  logic             accept;
  logic             slot_free;

  // A clear cycle swallows the presented bit.
  assign accept    = in_valid & in_ready_q & ~clr;
  assign slot_free = ~out_valid_q | out_ready;

  // Bit position inside the word for the current idx.
  assign pos = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

  // Write-enable demux: only the addressed bit takes in_bit.
  // All other bits keep their shadow value.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_demux
      assign shadow_wr[gi] = (accept && (pos == SEL_W'(gi))) ? in_bit : shadow_q[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_word_d  = out_word_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q | (in_valid & ~in_ready_q & ~clr);

    // A consumed word frees the slot.
    // A load later in this block can set out_valid again.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      idx_d    = '0;
      shadow_d = '0;
      state_d  = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            shadow_d = shadow_wr;
            // Counter wraps naturally to 0 after the last position.
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              if (slot_free) begin
                out_word_d  = shadow_wr;
                out_valid_d = 1'b1;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: begin
          // out_valid is necessarily 1 here, so out_ready alone means transfer.
          if (out_ready) begin
            out_word_d  = shadow_q;
            out_valid_d = 1'b1;
            state_d     = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end

    // Registered from next state: no combinational path out_ready -> in_ready.
    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      shadow_q    <= '0;
      out_word_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_word_q  <= out_word_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign sel       = idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux32_deser.sv
// -----------------------------------------------------------------------------
// tb_demux32_deser
//
// Directed bench for demux32_deser. It uses two instances:
//   u_lsb  (MSB_FIRST=0)
//   u_msb  (MSB_FIRST=1)
// The two instances share clk and rst_n.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_demux32_deser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_clr = 1'b0, a_in_bit = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic        a_in_ready, a_out_valid, a_overrun;
  logic [31:0] a_out_word;
  logic [4:0]  a_sel;

  logic        b_clr = 1'b0, b_in_bit = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid, b_overrun;
  logic [31:0] b_out_word;
  logic [4:0]  b_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux32_deser #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_bit(a_in_bit), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_word(a_out_word), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sel(a_sel), .overrun(a_overrun)
  );

  demux32_deser #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_bit(b_in_bit), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_word(b_out_word), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sel(b_sel), .overrun(b_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32 bits, LSB first, into u_lsb.
  task automatic a_send(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      a_in_valid = 1'b1;
      a_in_bit   = w[i];
      tick();
    end
    a_in_valid = 1'b0;
  endtask

  // 32 bits, MSB first, into u_msb.
  task automatic b_send(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      b_in_valid = 1'b1;
      b_in_bit   = w[31-i];
      tick();
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word: got %h want 00000000", a_out_word); end
    checks++; if (a_sel !== 5'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", a_sel); end
    checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", a_overrun); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_lsb: got %b want 1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_msb: got %b want 1", b_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_msb: got %b want 0", b_out_valid); end
    $display("reset: done");
  endtask

  task automatic test_lsb_word();
    logic [31:0] w;
    w = 32'hA5C3_0F96;
    a_out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_in_valid = 1'b1;
      a_in_bit   = w[i];
      tick();
      if (i == 30) begin
        checks++; if (a_sel !== 5'd31) begin errors++; $display("FAIL lsb_sel_31: got %0d want 31", a_sel); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lsb_early_valid: got %b want 0", a_out_valid); end
      end
    end
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL lsb_out_valid: got %b want 1", a_out_valid); end
    checks++; if (a_out_word !== 32'hA5C30F96) begin errors++; $display("FAIL lsb_out_word: got %h want a5c30f96", a_out_word); end
    checks++; if (a_sel !== 5'd0) begin errors++; $display("FAIL lsb_sel_wrap: got %0d want 0", a_sel); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lsb_consumed: got %b want 0", a_out_valid); end
    checks++; if (a_out_word !== 32'hA5C30F96) begin errors++; $display("FAIL lsb_word_hold: got %h want a5c30f96", a_out_word); end
    $display("lsb_word: sent a5c30f96 got %h", a_out_word);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w2 [2];
    logic        went_low;
    w2[0] = 32'hA5C3_0F96;
    w2[1] = 32'h0000_0001;
    went_low = 1'b0;
    b_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        b_in_valid = 1'b1;
        b_in_bit   = w2[k][31-i];
        tick();
        if (b_in_ready !== 1'b1) went_low = 1'b1;
      end
      checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b want 1", k, b_out_valid); end
      checks++; if (b_out_word !== w2[k]) begin errors++; $display("FAIL b2b_word_%0d: got %h want %h", k, b_out_word, w2[k]); end
      $display("back_to_back: word %0d got %h", k, b_out_word);
    end
    b_in_valid = 1'b0;
    checks++; if (went_low !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got low want always 1"); end
    tick();
  endtask

  task automatic test_hold_overrun();
    a_out_ready = 1'b0;
    a_send(32'h1234_5678);
    checks++; if (a_out_word !== 32'h12345678) begin errors++; $display("FAIL hold_first_word: got %h want 12345678", a_out_word); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL hold_first_ready: got %b want 1", a_in_ready); end
    a_send(32'hDEAD_BEEF);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", a_in_ready); end
    checks++; if (a_out_word !== 32'h12345678) begin errors++; $display("FAIL hold_out_word: got %h want 12345678", a_out_word); end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid: got %b want 1", a_out_valid); end
    checks++; if (a_sel !== 5'd0) begin errors++; $display("FAIL hold_sel: got %0d want 0", a_sel); end
    checks++; if (a_overrun !== 1'b0) begin errors++; $display("FAIL hold_no_overrun_yet: got %b want 1'b0", a_overrun); end
    // Push zeros while stalled; they must not reach the held word.
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_bit   = 1'b0;
      tick();
    end
    a_in_valid = 1'b0;
    checks++; if (a_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", a_overrun); end
    tick();
    checks++; if (a_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", a_overrun); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_still_stalled: got %b want 0", a_in_ready); end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_word !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_release_word: got %h want deadbeef", a_out_word); end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_release_valid: got %b want 1", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %b want 0", a_out_valid); end
    checks++; if (a_overrun !== 1'b1) begin errors++; $display("FAIL overrun_after_drain: got %b want 1", a_overrun); end
    $display("hold_overrun: released %h overrun=%b", a_out_word, a_overrun);
  endtask

  task automatic test_clr();
    b_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'b1;
      b_in_bit   = 1'b1;
      tick();
    end
    checks++; if (b_sel !== 5'd10) begin errors++; $display("FAIL clr_partial_sel: got %0d want 10", b_sel); end
    b_clr      = 1'b1;
    b_in_valid = 1'b1;
    b_in_bit   = 1'b1;
    tick();
    b_clr      = 1'b0;
    b_in_valid = 1'b0;
    checks++; if (b_sel !== 5'd0) begin errors++; $display("FAIL clr_sel: got %0d want 0", b_sel); end
    checks++; if (b_overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun: got %b want 0", b_overrun); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL clr_no_word: got %b want 0", b_out_valid); end
    b_send(32'h0F0F_1234);
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL clr_next_valid: got %b want 1", b_out_valid); end
    checks++; if (b_out_word !== 32'h0F0F1234) begin errors++; $display("FAIL clr_next_word: got %h want 0f0f1234", b_out_word); end
    $display("clr: next word got %h", b_out_word);
    tick();
  endtask

  task automatic test_async_reset();
    logic spurious;
    spurious = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'b1;
      a_in_bit   = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    checks++; if (a_sel !== 5'd20) begin errors++; $display("FAIL areset_pre_sel: got %0d want 20", a_sel); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_sel !== 5'd0) begin errors++; $display("FAIL areset_sel: got %0d want 0", a_sel); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_word !== 32'h0) begin errors++; $display("FAIL areset_word: got %h want 00000000", a_out_word); end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_out_valid !== 1'b0) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL areset_spurious: got word want none"); end
    a_send(32'hCAFE_F00D);
    checks++; if (a_out_word !== 32'hCAFEF00D) begin errors++; $display("FAIL areset_after_word: got %h want cafef00d", a_out_word); end
    $display("async_reset: post-reset word %h", a_out_word);
  endtask

  initial begin
    test_reset();
    test_lsb_word();
    test_back_to_back();
    test_hold_overrun();
    test_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
